ysyx_22050133_axi_test_master: RTL and testbench

- AXI4 initiator (master) that drives the core's io_slave AXI port, which the NPC top currently ties to zero.
- Turns simple one-at-a-time read/write burst commands into AXI4 INCR bursts.
- Streams write beats in and read beats out.
- Used by the simulation top to preload memory or inspect it through the core's slave port, and as the DMA engine's AXI front end.

---
 rtl/ysyx_22050133_axi_pkg.sv | 13 +
 rtl/ysyx_22050133_axi_test_master_if.sv | 39 +++
 rtl/ysyx_22050133_axi_burst_chk.sv | 24 ++
 rtl/ysyx_22050133_axi_test_master.sv | 107 ++++++++++
 tb/tb_ysyx_22050133_axi_test_master.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050133_axi_pkg.sv
// ysyx_22050133_axi_pkg: shared AXI encodings, widths and test-master FSM states
package ysyx_22050133_axi_pkg;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_ID_WIDTH = 4;
  localparam logic [AXI_ID_WIDTH-1:0] MST_ID = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, ERR, DONE} state_t;
endpackage

// File: rtl/ysyx_22050133_axi_test_master_if.sv
// ysyx_22050133_axi_test_master_if: AXI4 bus between the test master and a slave
interface ysyx_22050133_axi_test_master_if import ysyx_22050133_axi_pkg::*;;
  logic aw_valid, aw_ready;
  logic [AXI_ID_WIDTH-1:0] aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0] aw_len;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic w_valid, w_ready, w_last;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic b_valid, b_ready;
  logic [AXI_ID_WIDTH-1:0] b_id;
  logic [1:0] b_resp;
  logic ar_valid, ar_ready;
  logic [AXI_ID_WIDTH-1:0] ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0] ar_len;
  logic [2:0] ar_size;
  logic [1:0] ar_burst;
  logic r_valid, r_ready, r_last;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [1:0] r_resp;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
    input r_valid, r_id, r_resp, r_data, r_last, output r_ready
  );
  modport slave (
    input aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
    input w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
    output r_valid, r_id, r_resp, r_data, r_last, input r_ready
  );
endinterface

// File: rtl/ysyx_22050133_axi_burst_chk.sv
// ysyx_22050133_axi_burst_chk: size/4 KB legality check and beat counter with last detect
module ysyx_22050133_axi_burst_chk import ysyx_22050133_axi_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [11:0] chk_addr,
  input  logic [7:0] chk_len,
  input  logic [2:0] chk_size,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       legal,
  output logic [7:0] cnt,
  output logic       last
);
  logic [13:0] beats, span;
  assign beats = 14'(chk_len) + 14'd1;
  assign span = 14'(chk_addr) + (beats << chk_size[1:0]);
  assign legal = !chk_size[2] && span <= 14'd4096;
  assign last = cnt == len;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
endmodule

// File: rtl/ysyx_22050133_axi_test_master.sv
// ysyx_22050133_axi_test_master: one-at-a-time command to AXI4 INCR burst initiator
module ysyx_22050133_axi_test_master import ysyx_22050133_axi_pkg::*; (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [2:0]                cmd_size_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
  input  logic [7:0]                wr_strb_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] rd_data_o,
  output logic                      rd_last_o,
  output logic                      done_o,
  output logic [1:0]                done_resp_o,
  ysyx_22050133_axi_test_master_if.master axi
);
  state_t state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0] len_q, cnt;
  logic [2:0] size_q;
  logic [1:0] resp_q, resp_nxt, done_resp_q;
  logic legal, last, accept, r_hs, w_hs;
  assign accept = state == IDLE && cmd_valid_i;
  assign r_hs = state == R && axi.r_valid && rd_ready_i;
  assign w_hs = state == W && wr_valid_i && axi.w_ready;
  ysyx_22050133_axi_burst_chk u_chk (
    .clk(clk), .rst(rst), .chk_addr(cmd_addr_i[11:0]), .chk_len(cmd_len_i), .chk_size(cmd_size_i),
    .clr(accept), .inc(r_hs || w_hs), .len(len_q), .legal(legal), .cnt(cnt), .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      resp_q <= RESP_OKAY;
      done_resp_q <= RESP_OKAY;
    end else begin
      state <= state_nxt;
      resp_q <= resp_nxt;
      if (accept) begin
        addr_q <= cmd_addr_i;
        len_q <= cmd_len_i;
        size_q <= cmd_size_i;
      end
      if (state_nxt == DONE) done_resp_q <= resp_nxt;
    end
  always_comb begin
    state_nxt = state;
    resp_nxt = resp_q;
    case (state)
      IDLE: if (cmd_valid_i) begin
        state_nxt = !legal ? ERR : cmd_write_i ? AW : AR;
        resp_nxt = RESP_OKAY;
      end
      AR: state_nxt = axi.ar_ready ? R : AR;
      R: if (r_hs) begin
        // a wrong ID or a misplaced rlast poisons the whole burst
        resp_nxt = (axi.r_id != MST_ID || axi.r_last != last) ? RESP_SLVERR
                 : axi.r_resp > resp_q ? axi.r_resp : resp_q;
        state_nxt = last ? DONE : R;
      end
      AW: state_nxt = axi.aw_ready ? W : AW;
      W: state_nxt = (w_hs && last) ? B : W;
      B: if (axi.b_valid) begin
        resp_nxt = axi.b_id != MST_ID ? RESP_SLVERR : axi.b_resp;
        state_nxt = DONE;
      end
      ERR: begin
        resp_nxt = RESP_SLVERR;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign cmd_ready_o = state == IDLE;
  assign done_o = state == DONE;
  assign done_resp_o = done_resp_q;
  assign axi.ar_valid = state == AR;
  assign axi.ar_id = MST_ID;
  assign axi.ar_addr = addr_q;
  assign axi.ar_len = len_q;
  assign axi.ar_size = size_q;
  assign axi.ar_burst = BURST_INCR;
  assign axi.aw_valid = state == AW;
  assign axi.aw_id = MST_ID;
  assign axi.aw_addr = addr_q;
  assign axi.aw_len = len_q;
  assign axi.aw_size = size_q;
  assign axi.aw_burst = BURST_INCR;
  assign axi.w_valid = state == W && wr_valid_i;
  assign axi.w_data = wr_data_i;
  assign axi.w_strb = wr_strb_i;
  assign axi.w_last = state == W && last;
  assign wr_ready_o = state == W && axi.w_ready;
  assign axi.b_ready = state == B;
  assign axi.r_ready = state == R && rd_ready_i;
  assign rd_valid_o = state == R && axi.r_valid;
  assign rd_data_o = axi.r_data;
  assign rd_last_o = state == R && last;
endmodule

// File: tb/tb_ysyx_22050133_axi_test_master.sv
// tb_ysyx_22050133_axi_test_master: directed checks of the AXI test master
module tb_ysyx_22050133_axi_test_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic [2:0] cmd_size = 0;
  logic wr_valid = 0, wr_ready;
  logic [63:0] wr_data = 0;
  logic [7:0] wr_strb = 0;
  logic rd_valid, rd_ready = 0, rd_last, done;
  logic [63:0] rd_data;
  logic [1:0] done_resp;
  int checks = 0, errors = 0;
  ysyx_22050133_axi_test_master_if bus ();
  ysyx_22050133_axi_test_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_o(done), .done_resp_o(done_resp), .axi(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s;
    while (!cmd_ready && n < 20) begin tick; n++; end
    chk("cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
  endtask
  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    chk("ar_valid", bus.ar_valid, 1);
    chk("ar_addr", bus.ar_addr, a);
    chk("ar_len", bus.ar_len, l);
    chk("ar_size", bus.ar_size, s);
    chk("ar_burst", bus.ar_burst, 1);
    chk("ar_id", bus.ar_id, 1);
    bus.ar_ready = 1;
    tick;
    bus.ar_ready = 0;
    chk("ar_drop", bus.ar_valid, 0);
  endtask
  task automatic rd_beat(input logic [63:0] d, input logic rl, input logic [1:0] rs, input logic exp_last);
    bus.r_valid = 1; bus.r_data = d; bus.r_last = rl; bus.r_resp = rs; bus.r_id = 4'd1;
    rd_ready = 1;
    #1;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, d);
    chk("rd_last", rd_last, exp_last);
    chk("r_ready", bus.r_ready, 1);
    tick;
    bus.r_valid = 0;
  endtask
  initial begin
    bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_id = 0; bus.b_resp = 0;
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_id = 0; bus.r_resp = 0; bus.r_data = 0; bus.r_last = 0;
    tick; tick;
    chk("rst_arvalid", bus.ar_valid, 0);
    chk("rst_awvalid", bus.aw_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", done_resp, 0);
    rst = 0;
    tick;
    chk("idle_ready", cmd_ready, 1);
    // 4-beat read
    send_cmd(0, 32'h8000_0000, 8'd3, 3'd3);
    do_ar(32'h8000_0000, 8'd3, 3'd3);
    for (int i = 0; i < 4; i++) rd_beat(64'hA000_0000_0000_0000 + 64'(i), i == 3, 2'b00, i == 3);
    chk("rd4_done", done, 1);
    chk("rd4_resp", done_resp, 0);
    tick;
    chk("rd4_done_pulse", done, 0);
    // 2-beat write with slave stalls
    send_cmd(1, 32'h8000_0100, 8'd1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      chk("aw_valid_stall", bus.aw_valid, 1);
      chk("aw_addr_stall", bus.aw_addr, 32'h8000_0100);
      tick;
    end
    chk("aw_len", bus.aw_len, 1);
    chk("aw_burst", bus.aw_burst, 1);
    bus.aw_ready = 1;
    tick;
    bus.aw_ready = 0;
    chk("aw_drop", bus.aw_valid, 0);
    wr_valid = 1; wr_data = 64'h1122_3344_5566_7788; wr_strb = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("w_valid_stall", bus.w_valid, 1);
      chk("wr_ready_stall", wr_ready, 0);
      tick;
    end
    bus.w_ready = 1;
    #1;
    chk("w_data0", bus.w_data, 64'h1122_3344_5566_7788);
    chk("w_strb0", bus.w_strb, 8'hFF);
    chk("w_last0", bus.w_last, 0);
    tick;
    wr_data = 64'h99AA_BBCC_DDEE_FF00;
    #1;
    chk("w_data1", bus.w_data, 64'h99AA_BBCC_DDEE_FF00);
    chk("w_last1", bus.w_last, 1);
    tick;
    #1;
    chk("w_no_extra", bus.w_valid, 0);
    chk("b_ready", bus.b_ready, 1);
    chk("b_wait_done", done, 0);
    wr_valid = 0; bus.w_ready = 0;
    bus.b_valid = 1; bus.b_id = 4'd1; bus.b_resp = 2'b00;
    tick;
    bus.b_valid = 0;
    chk("wr_done", done, 1);
    chk("wr_resp", done_resp, 0);
    tick;
    // 4 KB crossing
    send_cmd(0, 32'h8000_0FF8, 8'd1, 3'd3);
    chk("err_no_ar", bus.ar_valid, 0);
    chk("err_no_aw", bus.aw_valid, 0);
    chk("err_no_done", done, 0);
    tick;
    chk("err_done", done, 1);
    chk("err_resp", done_resp, 2'b10);
    tick;
    chk("err_done_pulse", done, 0);
    chk("err_resp_hold", done_resp, 2'b10);
    // size above 3
    send_cmd(0, 32'h8000_0000, 8'd0, 3'd4);
    chk("sz_no_ar", bus.ar_valid, 0);
    tick;
    chk("sz_done", done, 1);
    chk("sz_resp", done_resp, 2'b10);
    tick;
    // ending exactly on a 4 KB boundary is legal; rd_ready stall mid-burst
    send_cmd(0, 32'h8000_0FF0, 8'd1, 3'd3);
    do_ar(32'h8000_0FF0, 8'd1, 3'd3);
    bus.r_valid = 1; bus.r_data = 64'h55; bus.r_last = 0; bus.r_resp = 0; bus.r_id = 4'd1;
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rready", bus.r_ready, 0);
      chk("stall_rdvalid", rd_valid, 1);
      tick;
    end
    rd_beat(64'h55, 0, 2'b00, 0);
    rd_beat(64'h66, 1, 2'b00, 1);
    chk("stall_done", done, 1);
    chk("stall_resp", done_resp, 0);
    tick;
    // mid-burst SLVERR and early rlast
    send_cmd(0, 32'h8000_0200, 8'd2, 3'd3);
    do_ar(32'h8000_0200, 8'd2, 3'd3);
    rd_beat(64'h1, 0, 2'b00, 0);
    rd_beat(64'h2, 1, 2'b10, 0);
    chk("early_last_no_done", done, 0);
    rd_beat(64'h3, 1, 2'b00, 1);
    chk("slverr_done", done, 1);
    chk("slverr_resp", done_resp, 2'b10);
    tick;
    // reset during write beat 1 of 4
    send_cmd(1, 32'h8000_2000, 8'd3, 3'd2);
    bus.aw_ready = 1;
    tick;
    bus.aw_ready = 0;
    wr_valid = 1; bus.w_ready = 1; wr_data = 64'hDEAD; wr_strb = 8'h0F;
    tick;
    chk("w_beat1_valid", bus.w_valid, 1);
    rst = 1;
    #1;
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_aw_valid", bus.aw_valid, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_resp", done_resp, 0);
    tick;
    chk("rst_hold_done", done, 0);
    rst = 0; wr_valid = 0; bus.w_ready = 0;
    tick;
    chk("post_rst_done", done, 0);
    send_cmd(0, 32'h8000_3000, 8'd0, 3'd3);
    do_ar(32'h8000_3000, 8'd0, 3'd3);
    rd_beat(64'hCAFE, 1, 2'b00, 1);
    chk("post_rst_cmd_done", done, 1);
    chk("post_rst_cmd_resp", done_resp, 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
